// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Purpose:
//   Sequences one 2*N-bit ADD/SUB/AND/OR operation over an external N-bit
//   combinational ALU in two passes, low word first and then high word.
//   The carry out of the low pass is fed back as carry-in for the high pass.
//   Handshake: a request is taken in IDLE. The result is then presented in
//   DONE until the consumer accepts it.
//
// Ports:
//   clk          in   1      clock, all state on rising edge
//   reset_n      in   1      asynchronous active-low reset
//   req_valid    in   1      request present
//   req_ready    out  1      controller idle, can take a request
//   op           in   2      00 ADD, 01 SUB, 10 AND, 11 OR
//   opa, opb     in   2N     operands
//   resp_valid   out  1      result available
//   resp_ready   in   1      consumer accepts result
//   res          out  2N     result
//   flags        out  4      {n,z,c,v}
//   alu_a, alu_b out  N      ALU operands
//   alu_ctl      out  3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 ADC
//   alu_carry    out  1      ALU carry-in (used by ADC)
//   alu_result   in   N      ALU result
//   alu_n/z/c/v  in   1      ALU flags
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [1:0]     op,
   input  logic [2*N-1:0] opa,
   input  logic [2*N-1:0] opb,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [2*N-1:0] res,
   output logic [3:0]     flags,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   output logic [2:0]     alu_ctl,
   output logic           alu_carry,
   input  logic [N-1:0]   alu_result,
   input  logic           alu_n,
   input  logic           alu_z,
   input  logic           alu_c,
   input  logic           alu_v
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LO   = 2'b01,
      HI   = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   localparam logic [2:0] CTL_AND = 3'b010;
   localparam logic [2:0] CTL_OR  = 3'b011;
   localparam logic [2:0] CTL_ADC = 3'b100;

   state_t         state_q, state_d;
   logic [1:0]     op_q;
   logic [2*N-1:0] opa_q;
   logic [2*N-1:0] opb_q;
   logic [N-1:0]   resLo_q;
   logic           zLo_q;
   logic           cLo_q;
   logic [2*N-1:0] res_q;
   logic [3:0]     flags_q;

   logic [N-1:0]   wordA;
   logic [N-1:0]   wordB;
   logic           isArith;

   assign isArith = (op_q == OP_ADD) || (op_q == OP_SUB);

   // Next-state and ALU drive.
   // The ALU operands stay at zero outside the two compute passes.
   // SUB is done as a + ~b + carry. The low pass injects the +1, and the
   // high pass chains the low-pass carry, which gives C=1 for "no borrow".
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      alu_a      = '0;
      alu_b      = '0;
      alu_ctl    = 3'b000;
      alu_carry  = 1'b0;
      wordA      = '0;
      wordB      = '0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = LO;
            end
         end
         LO: begin
            wordA   = opa_q[N-1:0];
            wordB   = opb_q[N-1:0];
            state_d = HI;
         end
         HI: begin
            wordA   = opa_q[2*N-1:N];
            wordB   = opb_q[2*N-1:N];
            state_d = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_q == LO) || (state_q == HI)) begin
         alu_a = wordA;
         case (op_q)
            OP_ADD: begin
               alu_ctl   = CTL_ADC;
               alu_b     = wordB;
               alu_carry = (state_q == LO) ? 1'b0 : cLo_q;
            end
            OP_SUB: begin
               alu_ctl   = CTL_ADC;
               alu_b     = ~wordB;
               alu_carry = (state_q == LO) ? 1'b1 : cLo_q;
            end
            OP_AND: begin
               alu_ctl = CTL_AND;
               alu_b   = wordB;
            end
            default: begin
               alu_ctl = CTL_OR;
               alu_b   = wordB;
            end
         endcase
      end
   end

   // State, operand capture and result registers.
   // The low word is kept internally and only lands on res together with
   // the high word. This way res and flags change only on the edge that
   // leaves HI, and a reset in LO/HI never exposes a partial result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         resLo_q <= '0;
         zLo_q   <= 1'b0;
         cLo_q   <= 1'b0;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  op_q  <= op;
                  opa_q <= opa;
                  opb_q <= opb;
               end
            end
            LO: begin
               resLo_q <= alu_result;
               zLo_q   <= alu_z;
               cLo_q   <= alu_c;
            end
            HI: begin
               res_q   <= {alu_result, resLo_q};
               flags_q <= {alu_n,
                           zLo_q & alu_z,
                           isArith & alu_c,
                           isArith & alu_v};
            end
            default: begin
            end
         endcase
      end
   end

   assign res   = res_q;
   assign flags = flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//
// Testbench for alu_seq_ctrl with N=32. It provides a combinational N-bit
// ALU and keeps a transaction-level reference model that works on whole
// 64-bit operands with plain arithmetic. A per-cycle compare process checks
// the DUT against that model. Directed cases pin the model with literal
// results. Randomized traffic, including random reset pulses, exercises
// the rest.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

   localparam int N = 32;
   localparam int W = 2 * N;

   logic           clk = 1'b0;
   logic           reset_n = 1'b1;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [1:0]     op = 2'b00;
   logic [W-1:0]   opa = '0;
   logic [W-1:0]   opb = '0;
   logic           resp_valid;
   logic           resp_ready = 1'b0;
   logic [W-1:0]   res;
   logic [3:0]     flags;
   logic [N-1:0]   alu_a;
   logic [N-1:0]   alu_b;
   logic [2:0]     alu_ctl;
   logic           alu_carry;
   logic [N-1:0]   alu_result;
   logic           alu_n;
   logic           alu_z;
   logic           alu_c;
   logic           alu_v;

   int vectors = 0;
   int misses  = 0;
   logic checkEn = 1'b0;

   alu_seq_ctrl #(.N(N)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .op         (op),
      .opa        (opa),
      .opb        (opb),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .res        (res),
      .flags      (flags),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctl    (alu_ctl),
      .alu_carry  (alu_carry),
      .alu_result (alu_result),
      .alu_n      (alu_n),
      .alu_z      (alu_z),
      .alu_c      (alu_c),
      .alu_v      (alu_v)
   );

   always #5 clk = ~clk;

   // External combinational ALU
   logic [N:0] aluWide;
   always_comb begin
      aluWide = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (alu_ctl)
         3'b000: begin
            aluWide = {1'b0, alu_a} + {1'b0, alu_b};
            alu_c   = aluWide[N];
            alu_v   = (alu_a[N-1] == alu_b[N-1]) && (aluWide[N-1] != alu_a[N-1]);
         end
         3'b001: begin
            aluWide = {1'b0, alu_a} - {1'b0, alu_b};
            alu_c   = (alu_a >= alu_b);
            alu_v   = (alu_a[N-1] != alu_b[N-1]) && (aluWide[N-1] != alu_a[N-1]);
         end
         3'b010: aluWide = {1'b0, alu_a & alu_b};
         3'b011: aluWide = {1'b0, alu_a | alu_b};
         3'b100: begin
            aluWide = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_carry};
            alu_c   = aluWide[N];
            alu_v   = (alu_a[N-1] == alu_b[N-1]) && (aluWide[N-1] != alu_a[N-1]);
         end
         default: aluWide = '0;
      endcase
      alu_result = aluWide[N-1:0];
      alu_n      = alu_result[N-1];
      alu_z      = (alu_result == '0);
   end

   // Whole-word result and {n,z,c,v} of one operation
   function automatic logic [W+3:0] refResult(input logic [1:0] o,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic [W:0]   wide;
      logic [W-1:0] r;
      logic         c;
      logic         v;
      c = 1'b0;
      v = 1'b0;
      case (o)
         2'b00: begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[W-1:0];
            c    = wide[W];
            v    = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         2'b01: begin
            r = a - b;
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         2'b10: r = a & b;
         default: r = a | b;
      endcase
      return {r, r[W-1], (r == '0), c, v};
   endfunction

   // What the controller should put on the ALU for one word pass
   function automatic logic [67:0] expDrive(input logic [1:0] o,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic isLow);
      logic [N-1:0] aw;
      logic [N-1:0] bw;
      logic [N:0]   lowSum;
      logic         cin;
      aw     = isLow ? a[N-1:0] : a[W-1:N];
      bw     = isLow ? b[N-1:0] : b[W-1:N];
      lowSum = {1'b0, a[N-1:0]} + {1'b0, b[N-1:0]};
      case (o)
         2'b00: begin
            cin = isLow ? 1'b0 : lowSum[N];
            return {aw, bw, 3'b100, cin};
         end
         2'b01: begin
            cin = isLow ? 1'b1 : (a[N-1:0] >= b[N-1:0]);
            return {aw, ~bw, 3'b100, cin};
         end
         2'b10: return {aw, bw, 3'b010, 1'b0};
         default: return {aw, bw, 3'b011, 1'b0};
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         misses++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: an accepted request yields its response two
   // edges later, and the response is held until resp_ready is seen.
   int           mWait = 0;
   logic         mBusy = 1'b0;
   logic         mValid = 1'b0;
   logic [1:0]   mOp = 2'b00;
   logic [W-1:0] mA = '0;
   logic [W-1:0] mB = '0;
   logic [W-1:0] mRes = '0;
   logic [3:0]   mFlags = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mBusy  = 1'b0;
         mValid = 1'b0;
         mWait  = 0;
         mRes   = '0;
         mFlags = '0;
      end else if (mValid) begin
         if (resp_ready) mValid = 1'b0;
      end else if (mBusy) begin
         mWait--;
         if (mWait == 0) begin
            {mRes, mFlags} = refResult(mOp, mA, mB);
            mBusy  = 1'b0;
            mValid = 1'b1;
         end
      end else if (req_valid) begin
         mBusy = 1'b1;
         mWait = 2;
         mOp   = op;
         mA    = opa;
         mB    = opb;
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("req_ready", 128'(req_ready), 128'(!mBusy && !mValid));
         checkOutput("resp_valid", 128'(resp_valid), 128'(mValid));
         checkOutput("res", 128'(res), 128'(mRes));
         checkOutput("flags", 128'(flags), 128'(mFlags));
         if (mBusy)
            checkOutput("alu_drive", 128'({alu_a, alu_b, alu_ctl, alu_carry}),
                        128'(expDrive(mOp, mA, mB, mWait == 2)));
         else
            checkOutput("alu_quiet", 128'({alu_a, alu_b, alu_ctl, alu_carry}), 128'(0));
      end
   end

   // One directed operation with literal expectations
   task automatic applyStimulus(input string name, input logic [1:0] o,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] expRes, input logic [3:0] expFlags);
      int cnt;
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      op  = o;
      opa = a;
      opb = b;
      cnt = 0;
      while (!req_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput({name, "_accept_wait"}, 128'(cnt), 128'(0));
      @(negedge clk);
      req_valid = 1'b0;
      cnt = 1;
      while (!resp_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput({name, "_edges_to_valid"}, 128'(cnt), 128'(3));
      checkOutput({name, "_res"}, 128'(res), 128'(expRes));
      checkOutput({name, "_flags"}, 128'(flags), 128'(expFlags));
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   function automatic logic [W-1:0] pickOperand();
      case ($urandom % 6)
         0: return '0;
         1: return '1;
         2: return {32'h0, 32'hFFFF_FFFF};
         3: return 64'h7FFF_FFFF_FFFF_FFFF;
         4: return 64'h8000_0000_0000_0000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      int cnt;
      #1 reset_n = 1'b0;
      checkEn = 1'b1;
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b1;

      // Directed cases with known answers
      applyStimulus("add_carry", 2'b00, 64'h00000000_FFFFFFFF, 64'h1,
                    64'h00000001_00000000, 4'b0000);
      applyStimulus("sub_equal", 2'b01, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0,
                    64'h0, 4'b0110);
      applyStimulus("sub_borrow", 2'b01, 64'h0, 64'h1, '1, 4'b1000);
      applyStimulus("add_ovf", 2'b00, 64'h7FFFFFFF_FFFFFFFF, 64'h1,
                    64'h80000000_00000000, 4'b1001);
      applyStimulus("and_zero", 2'b10, 64'hF0F0F0F0_F0F0F0F0, 64'h0F0F0F0F_0F0F0F0F,
                    64'h0, 4'b0100);
      applyStimulus("or_ones", 2'b11, 64'hF0F0F0F0_F0F0F0F0, 64'h0F0F0F0F_0F0F0F0F,
                    '1, 4'b1000);

      // Backpressure with a competing request held high
      @(negedge clk);
      req_valid = 1'b1; op = 2'b00; opa = 64'd5; opb = 64'd7; resp_ready = 1'b0;
      @(negedge clk);
      op = 2'b11; opa = 64'h00FF00FF_00000000; opb = 64'h0000000F_0000000F;
      cnt = 0;
      while (!resp_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", 128'(resp_valid), 128'(1));
         checkOutput("bp_ready", 128'(req_ready), 128'(0));
         checkOutput("bp_res", 128'(res), 128'(12));
         checkOutput("bp_flags", 128'(flags), 128'(0));
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      checkOutput("bp_back_idle", 128'({req_ready, resp_valid}), 128'(2'b10));
      @(negedge clk);
      req_valid = 1'b0;
      cnt = 0;
      while (!resp_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("bp_second_res", 128'(res), 128'(64'h00FF00FF_0000000F));
      checkOutput("bp_second_flags", 128'(flags), 128'(0));
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;

      // Reset pulse while the high word is being computed
      @(negedge clk);
      req_valid = 1'b1; op = 2'b00; opa = 64'h1; opb = 64'h2; resp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("rst_valid", 128'(resp_valid), 128'(0));
      checkOutput("rst_res", 128'(res), 128'(0));
      checkOutput("rst_ready", 128'(req_ready), 128'(1));
      @(negedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("rst_no_resp", 128'(resp_valid), 128'(0));
      end
      applyStimulus("after_rst", 2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 64'h1, 4'b0010);

      // Randomized traffic checked by the model
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         req_valid  = ($urandom % 3) != 0;
         op         = 2'($urandom);
         opa        = pickOperand();
         opb        = pickOperand();
         resp_ready = ($urandom % 4) != 0;
         if (($urandom % 150) == 0) begin
            #1 reset_n = 1'b0;
            #2 reset_n = 1'b1;
         end
      end

      @(negedge clk);
      req_valid = 1'b0;
      checkEn   = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
